// File: rtl/adder_result_acc.sv
// rtl/adder_result_acc.sv - accumulates COUNT adder {cout,sum} results into one block total
// Valid/ready on both sides; the total is held in DONE until the sink takes it.
module adder_result_acc #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 6,
  parameter int COUNT     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 cout,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 ovf
);

  if (ACC_WIDTH < WIDTH + 1) begin : g_bad_acc_width
    $error("adder_result_acc: ACC_WIDTH must be at least WIDTH+1");
  end
  if (COUNT < 2 || COUNT > 255) begin : g_bad_count
    $error("adder_result_acc: COUNT must lie in 2..255");
  end

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam logic [7:0] LAST = 8'(COUNT - 1);

  state_t               state;
  state_t               state_nxt;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_nxt;
  logic                 ovf_q;
  logic                 ovf_nxt;
  logic [7:0]           cnt;
  logic [7:0]           cnt_nxt;
  logic [ACC_WIDTH:0]   operand;
  logic [ACC_WIDTH:0]   acc_sum;
  logic                 in_fire;
  logic                 out_fire;

  // One extra bit on the adder so the wrap carry can feed the sticky flag.
  assign operand  = {{(ACC_WIDTH - WIDTH){1'b0}}, cout, sum};
  assign acc_sum  = {1'b0, acc} + operand;

  assign in_ready  = (state == ACCUM) && !rst;
  assign out_valid = (state == DONE);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign acc_out   = acc;
  assign ovf       = ovf_q;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf_q;
    cnt_nxt   = cnt;
    case (state)
      ACCUM: begin
        if (in_fire) begin
          acc_nxt = acc_sum[ACC_WIDTH-1:0];
          ovf_nxt = ovf_q | acc_sum[ACC_WIDTH];
          if (cnt == LAST) begin
            cnt_nxt   = 8'd0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      DONE: begin
        // Inputs are ignored here; the upstream holds its data until ACCUM.
        if (out_fire) begin
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
          state_nxt = ACCUM;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      ovf_q <= 1'b0;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      ovf_q <= ovf_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_adder_result_acc.sv
// tb/tb_adder_result_acc.sv - scoreboard bench for adder_result_acc
// Driver pushes expected block totals; a monitor pops them on each output handshake.
module tb_adder_result_acc;

  localparam int WIDTH     = 4;
  localparam int ACC_WIDTH = 6;
  localparam int COUNT     = 4;
  localparam int MODV      = 1 << ACC_WIDTH;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 ovf;

  adder_result_acc #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .COUNT(COUNT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .cout(cout), .acc_out(acc_out), .out_valid(out_valid),
    .out_ready(out_ready), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int blk_n = 0;
  int blk_sum = 0;
  int exp_acc_q[$];
  int exp_ovf_q[$];
  bit rand_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: a block total is the plain integer sum mod 2^ACC_WIDTH; since
  // every operand is non-negative and below the modulus, a wrap happened
  // exactly when the unreduced sum reached the modulus.
  task automatic model_accept(input int v);
    blk_sum += v;
    blk_n++;
    if (blk_n == COUNT) begin
      exp_acc_q.push_back(blk_sum % MODV);
      exp_ovf_q.push_back(blk_sum >= MODV ? 1 : 0);
      blk_n = 0;
      blk_sum = 0;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int a, input int b);
    int s;
    bit got;
    s = a + b;
    sum = s[WIDTH-1:0];
    cout = s[WIDTH];
    in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    if (got) model_accept(s);
    else check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Asserted between edges; outputs must clear without a clock.
  task automatic pulse_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_rst_out_valid"}, out_valid, 0);
    check({tag, "_rst_acc_out"}, acc_out, 0);
    check({tag, "_rst_ovf"}, ovf, 0);
    check({tag, "_rst_in_ready"}, in_ready, 0);
    blk_n = 0;
    blk_sum = 0;
    exp_acc_q.delete();
    exp_ovf_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check({tag, "_post_rst_in_ready"}, in_ready, 1);
  endtask

  // Scoreboard monitor: inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_acc_q.size() == 0) begin
        check("sb_unexpected_total", 1, 0);
      end else begin
        check("sb_acc_out", acc_out, exp_acc_q.pop_front());
        check("sb_ovf", ovf, exp_ovf_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t[3];
    rst = 1'b1;
    in_valid = 1'b0;
    sum = '0;
    cout = 1'b0;
    out_ready = 1'b0;
    rand_done = 1'b0;
    #1;
    check("init_out_valid", out_valid, 0);
    check("init_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    pulse_reset("idle");

    // Basic block: 1+5+9+19 = 34
    send(0, 1); send(2, 3); send(4, 5);
    check("basic_not_done_early", out_valid, 0);
    send(9, 10);
    check("basic_out_valid", out_valid, 1);
    check("basic_acc_out", acc_out, 34);
    check("basic_ovf", ovf, 0);
    check("basic_in_ready", in_ready, 0);

    // Backpressure with in_valid held high
    in_valid = 1'b1; sum = 4'd3; cout = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("bp_out_valid", out_valid, 1);
      check("bp_acc_out", acc_out, 34);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("bp_rel_acc_out", acc_out, 0);
    check("bp_rel_ovf", ovf, 0);
    check("bp_rel_in_ready", in_ready, 1);
    check("bp_rel_out_valid", out_valid, 0);

    // Overflow: 30 each, wraps on the third accept
    send(15, 15); send(15, 15);
    check("ovf_acc2", acc_out, 60);
    check("ovf_clear2", ovf, 0);
    send(15, 15);
    check("ovf_acc3", acc_out, 26);
    check("ovf_set3", ovf, 1);
    send(15, 15);
    check("ovf_final_acc", acc_out, 56);
    check("ovf_final_flag", ovf, 1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;

    // Gaps, then reset mid-block discards the partial sum
    send(0, 1);
    idle(3);
    send(2, 3);
    idle(2);
    pulse_reset("mid");
    send(0, 1); send(2, 3); send(4, 5); send(9, 10);
    check("mid_acc_out", acc_out, 34);
    out_ready = 1'b1;
    idle(1);

    // Back-to-back blocks of operand 1
    fork
      begin
        for (int i = 0; i < 3 * COUNT; i++) send(0, 1);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          bit seen;
          seen = 1'b0;
          for (int j = 0; j < 50 && !seen; j++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
          end
          if (!seen) check("b2b_timeout", 0, 1);
          t[k] = cyc;
          check("b2b_acc_out", acc_out, 4);
          @(negedge clk);
        end
      end
    join
    check("b2b_period_a", t[1] - t[0], COUNT + 1);
    check("b2b_period_b", t[2] - t[1], COUNT + 1);
    idle(2);

    // Randomized traffic with random gaps and backpressure
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
          send($urandom_range(15), $urandom_range(15));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = $urandom_range(1);
        end
      end
    join
    out_ready = 1'b1;
    idle(20);
    check("sb_drained", exp_acc_q.size(), 0);
    check("sb_partial", blk_n, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
